gen_pixel_packer: RTL and testbench

Downstream stage of generator_v2. Consumes the generator's final-layer stream (valid_out/data_out, signed fixed-point, no backpressure) and converts each sample to an unsigned 8-bit pixel. Tags each pixel with raster position markers (SOF/EOL/EOF). Buffers pixels in a small FIFO behind a valid/ready master port for a frame sink or DMA.

---
 rtl/gen_pixel_packer.sv | 205 ++++++++++++++++++++
 tb/tb_gen_pixel_packer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gen_pixel_packer.sv
// Converts signed fixed-point generator samples into raster-tagged 8-bit pixels behind a FWFT FIFO.
// Latency: a sample captured at edge N is pushed at edge N+1 and presented on m_* after that edge.
// Backpressure: m_ready stalls the FIFO only; the input never stalls, so pushes to a full FIFO are dropped and flagged.

// Generic first-word-fall-through FIFO with a one-bit-wider pointer pair.
// Latency: a write appears at the head on the edge after the push when the FIFO was empty.
// Backpressure: a push while full is accepted only if a pop happens on the same edge.
module gen_pixel_packer_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Full when the low bits match but the wrap bits differ; empty when both match.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_rd = pop && !empty;
    do_wr = push && (!full || do_rd);
    rdat  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer advance; storage itself needs no reset because the head is gated by empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry write.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdat;
  end
endmodule

module gen_pixel_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  frame_start,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [7:0]            m_pixel,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  overflow,
  input  logic                  clear_err,
  output logic [15:0]           frame_count,
  output logic                  frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic signed [DATA_WIDTH:0] ONE    = (DATA_WIDTH+1)'(1) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH:0] PIXMAX = (DATA_WIDTH+1)'(255);

  // Stored entry layout: {eof, eol, sof, pixel}.
  typedef struct packed {
    logic       eof;
    logic       eol;
    logic       sof;
    logic [7:0] pixel;
  } pix_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  logic signed [DATA_WIDTH:0] sum;
  logic signed [DATA_WIDTH:0] sh;
  pix_t conv;

  logic stg_vld;
  pix_t stg_dat;

  pix_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic ovf_set;

  // Raster position seen by this cycle's sample; frame_start forces it to (0,0).
  always_comb begin
    col_eff = frame_start ? '0 : col;
    row_eff = frame_start ? '0 : row;
    col_nxt = col_eff + 1'b1;
    row_nxt = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
    end
  end

  // Fixed-point to pixel: offset by +1.0, scale to 8 integer bits, saturate to 0..255.
  always_comb begin
    sum = $signed({data_in[DATA_WIDTH-1], data_in}) + ONE;
    sh  = sum >>> (FRAC_BITS - 7);
    conv.sof = (row_eff == '0) && (col_eff == '0);
    conv.eol = (col_eff == COL_LAST);
    conv.eof = conv.eol && (row_eff == ROW_LAST);
    if (sh[DATA_WIDTH])   conv.pixel = 8'd0;
    else if (sh > PIXMAX) conv.pixel = 8'd255;
    else                  conv.pixel = sh[7:0];
  end

  // Raster counters advance on every sample, dropped or not, so alignment survives overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      col <= col_nxt;
      row <= row_nxt;
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // Frames are counted on acceptance of the last-pixel sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       frame_count <= '0;
    else if (valid_in && conv.eof) frame_count <= frame_count + 16'd1;
  end

  // Conversion stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= 1'b0;
      stg_dat <= '0;
    end else begin
      stg_vld <= valid_in;
      if (valid_in) stg_dat <= conv;
    end
  end

  gen_pixel_packer_fifo #(
    .W     ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stg_vld),
    .wdat  (stg_dat),
    .pop   (pop),
    .rdat  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head presentation; gated so outputs read zero while empty.
  always_comb begin
    m_valid = !fifo_empty;
    pop     = m_valid && m_ready;
    ovf_set = stg_vld && fifo_full && !pop;
    m_pixel = m_valid ? head.pixel : 8'd0;
    m_sof   = m_valid && head.sof;
    m_eol   = m_valid && head.eol;
    m_eof   = m_valid && head.eof;
  end

  // Sticky drop flag; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (clear_err) overflow <= 1'b0;
  end

  // One-cycle pulse after the end-of-frame pixel leaves the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= pop && m_eof;
  end
endmodule

// File: tb/tb_gen_pixel_packer.sv
module tb_gen_pixel_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        frame_start = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [7:0]  m_pixel;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;
  logic        overflow;
  logic        clear_err = 1'b0;
  logic [15:0] frame_count;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int pos = 0;
  int exp_fc = 0;
  int fd_cnt = 0;
  logic [10:0] q[$];

  gen_pixel_packer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .frame_start(frame_start), .m_ready(m_ready), .m_valid(m_valid),
    .m_pixel(m_pixel), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .overflow(overflow), .clear_err(clear_err), .frame_count(frame_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Data word that converts exactly to pixel p (p in 0..255).
  function automatic logic [15:0] dpix(input int p);
    return 16'((p - 128) * 2);
  endfunction

  // One clock: apply inputs, check the head if it pops this edge, advance, sample #1 later.
  task automatic cyc(input logic v, input logic [15:0] d, input logic fs, input logic rdy,
                     input logic clr, input logic pe, input logic [7:0] ep);
    int p;
    logic sof, eol, eof;
    valid_in = v; data_in = d; frame_start = fs; m_ready = rdy; clear_err = clr;
    if (m_valid && rdy) begin
      if (q.size() == 0) chk("unexpected_pop", {21'd0, m_eof, m_eol, m_sof, m_pixel}, 32'hFFFF_FFFF);
      else chk("head", {21'd0, m_eof, m_eol, m_sof, m_pixel}, {21'd0, q.pop_front()});
    end
    if (v) begin
      p = fs ? 0 : pos;
      sof = (p == 0);
      eol = (p % 32) == 31;
      eof = (p == 1023);
      if (eof) exp_fc++;
      if (pe) q.push_back({eof, eol, sof, ep});
      pos = (p + 1) % 1024;
    end else if (fs) begin
      pos = 0;
    end
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    valid_in = 1'b0; frame_start = 1'b0; clear_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    chk({tag, "_drained"}, q.size(), 0);
    chk({tag, "_empty"}, m_valid, 0);
  endtask

  initial begin
    logic [15:0] t1_dat [7];
    logic [7:0]  t1_exp [7];
    t1_dat = '{16'h0000, 16'h0080, 16'hFF80, 16'h0100, 16'hFF00, 16'h7FFF, 16'h8000};
    t1_exp = '{8'd128, 8'd192, 8'd64, 8'd255, 8'd0, 8'd255, 8'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pixel", m_pixel, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // 1: conversion and latency
    cyc(1, t1_dat[0], 0, 1, 0, 1, t1_exp[0]);
    chk("lat_n1", m_valid, 0);
    cyc(1, t1_dat[1], 0, 1, 0, 1, t1_exp[1]);
    chk("lat_n2", m_valid, 1);
    for (int i = 2; i < 7; i++) cyc(1, t1_dat[i], 0, 1, 0, 1, t1_exp[i]);
    drain("conv");

    // 2: full frame
    fd_cnt = 0;
    for (int i = 0; i < 1024; i++) cyc(1, dpix(i % 256), (i == 0), 1, 0, 1, 8'(i % 256));
    drain("frame");
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("frame_count_1", frame_count, 1);
    chk("frame_ovf", overflow, 0);

    // 3: backpressure and overflow
    for (int i = 0; i < 16; i++) cyc(1, dpix(i), 0, 0, 0, 1, 8'(i));
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("bp16_ovf", overflow, 0);
    chk("bp16_valid", m_valid, 1);
    chk("bp16_head", m_pixel, 0);
    cyc(1, dpix(16), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("bp17_ovf", overflow, 1);
    drain("bp");
    chk("bp_ovf_sticky", overflow, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("bp_clear", overflow, 0);

    // 4: full boundary, push+pop while full, set beats clear
    for (int i = 0; i < 16; i++) cyc(1, dpix(100 + i), 0, 0, 0, 1, 8'(100 + i));
    cyc(1, dpix(200), 0, 0, 0, 1, 8'd200);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("full_pushpop_ovf", overflow, 0);
    cyc(1, dpix(201), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("set_beats_clear", overflow, 1);
    drain("full");
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("full_clear", overflow, 0);

    // 5: resync with sample 101
    for (int i = 0; i < 100; i++) cyc(1, dpix(i), 0, 1, 0, 1, 8'(i));
    for (int i = 0; i < 40; i++) cyc(1, dpix(i + 50), (i == 0), 1, 0, 1, 8'(i + 50));
    drain("resync");

    // 6: asynchronous reset mid-frame
    for (int i = 0; i < 500; i++) cyc(1, dpix(i % 256), 0, 1, 0, 1, 8'(i % 256));
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_fc", frame_count, 32'(exp_fc));
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_fc", frame_count, 0);
    q.delete();
    pos = 0;
    exp_fc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, dpix(77), 0, 1, 0, 1, 8'd77);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("post_rst_sof", m_sof, 1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
